// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a small FIFO that a
// serializer drains onto tx; the status word is readable combinationally.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] ADDR_TX      = 32'hFFFF_0000,
  parameter logic [31:0] ADDR_STATUS  = 32'hFFFF_0004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int BAUDW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [BAUDW-1:0] BAUD_MAX = BAUDW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [BAUDW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_q, tx_n;
  logic             pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          empty, full, tx_active;
  logic          hit_tx, hit_status, push_req, push, clr_ovf;
  logic          unused_bits;

  assign hit_tx      = (address == ADDR_TX);
  assign hit_status  = (address == ADDR_STATUS);
  assign sel         = hit_tx | hit_status;
  assign push_req    = mem_write & hit_tx;
  assign push        = push_req & ~full;
  assign clr_ovf     = mem_write & hit_status & write_data[3];
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign tx_active   = (state != IDLE);
  assign busy        = tx_active | ~empty;
  assign tx          = tx_q;
  assign unused_bits = ^write_data[31:8];

  assign read_data = (mem_read && hit_status)
                     ? {28'b0, overflow, tx_active, full, empty} : 32'b0;

  // Storage has no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= write_data[7:0];
  end

  // A push into a full FIFO is dropped even if a pop frees a slot this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  // tx_n is the line level for the next state, so tx comes straight off a flop.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
          baud_cnt_n = '0;
          state_n    = START;
          tx_n       = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
          tx_n       = shift[0];
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == BAUD_MAX) begin
          baud_cnt_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;

  logic        clock, reset;
  logic        mem_write, mem_read;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        sel, tx, busy;
  int          checks, errors;
  logic [31:0] st;

  mmio_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4),
    .ADDR_TX     (A_TX),
    .ADDR_STATUS (A_ST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .sel       (sel),
    .tx        (tx),
    .busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Line level i cycles into a frame (i = 0 is the first edge after the pop).
  function automatic logic exp_tx(input logic [7:0] b, input int i);
    if (i < 4)       return 1'b0;
    else if (i < 36) return b[(i - 4) / 4];
    else             return 1'b1;
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write  = 1'b1;
    address    = a;
    write_data = d;
    @(posedge clock);
    #1;
    mem_write  = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    mem_read = 1'b1;
    address  = A_ST;
    #1;
    v        = read_data;
    mem_read = 1'b0;
    address  = 32'h0;
  endtask

  task automatic check_frame(input logic [7:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("frame_%h_tx_%0d", b, i), {31'b0, tx}, {31'b0, exp_tx(b, i)});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;

    // Reset
    reset = 1'b1;
    #20;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_tx", {31'b0, tx}, 32'h1);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    mem_read = 1'b1;
    address  = A_ST;
    #1;
    chk("reset_sel", {31'b0, sel}, 32'h1);
    chk("reset_status", read_data, 32'h1);
    mem_read = 1'b0;
    address  = 32'h0;

    // Single byte 0xA5
    store(A_TX, 32'h0000_00A5);
    chk("single_busy_n", {31'b0, busy}, 32'h1);
    check_frame(8'hA5, 0, 39);
    chk("single_busy_n40", {31'b0, busy}, 32'h1);
    @(posedge clock);
    #1;
    chk("single_busy_n41", {31'b0, busy}, 32'h0);
    chk("single_tx_n41", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("single_status_idle", st, 32'h1);

    // Overflow: six stores on consecutive edges
    store(A_TX, 32'h01);
    for (int k = 1; k <= 5; k++) begin
      store(A_TX, 32'(k + 1));
      chk($sformatf("ovf_tx_%0d", k), {31'b0, tx}, {31'b0, exp_tx(8'h01, k - 1)});
    end
    read_status(st);
    chk("ovf_status", st, 32'hE);
    check_frame(8'h01, 5, 38);

    // Clear overflow on the last edge of frame 0x01
    store(A_ST, 32'h8);
    chk("clr_tx_39", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("clr_status", st, 32'h6);
    check_frame(8'h02, 0, 39);
    check_frame(8'h03, 0, 39);
    check_frame(8'h04, 0, 39);
    check_frame(8'h05, 0, 39);
    chk("ovf_busy_last", {31'b0, busy}, 32'h1);
    @(posedge clock);
    #1;
    chk("ovf_busy_end", {31'b0, busy}, 32'h0);
    chk("ovf_tx_end", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("ovf_status_end", st, 32'h1);

    // Reset during DATA bit 3, with a second byte queued
    store(A_TX, 32'h3C);
    store(A_TX, 32'h3D);
    chk("rst_tx_0", {31'b0, tx}, {31'b0, exp_tx(8'h3C, 0)});
    check_frame(8'h3C, 1, 17);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_tx_async", {31'b0, tx}, 32'h1);
    chk("rst_busy_async", {31'b0, busy}, 32'h0);
    read_status(st);
    chk("rst_status_in_reset", st, 32'h1);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("rst_idle_tx_%0d", k), {31'b0, tx}, 32'h1);
    end
    chk("rst_busy_after", {31'b0, busy}, 32'h0);
    read_status(st);
    chk("rst_status_after", st, 32'h1);

    // Decode
    mem_read = 1'b1;
    address  = 32'hFFFF_0008;
    #1;
    chk("dec_sel_0008", {31'b0, sel}, 32'h0);
    chk("dec_rd_0008", read_data, 32'h0);
    address = 32'h0000_0000;
    #1;
    chk("dec_sel_0000", {31'b0, sel}, 32'h0);
    chk("dec_rd_0000", read_data, 32'h0);
    address = A_TX;
    #1;
    chk("dec_sel_tx", {31'b0, sel}, 32'h1);
    chk("dec_rd_tx", read_data, 32'h0);
    mem_read = 1'b0;
    #1;
    chk("dec_rd_noread", read_data, 32'h0);
    address = 32'h0;
    store(32'hFFFF_0008, 32'h55);
    store(32'h0000_0000, 32'hAA);
    chk("dec_busy", {31'b0, busy}, 32'h0);
    chk("dec_tx", {31'b0, tx}, 32'h1);
    read_status(st);
    chk("dec_status", st, 32'h1);
    @(posedge clock);
    #1;
    chk("dec_tx_later", {31'b0, tx}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
